// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan controller.
//   seg_t           7-bit segment vector {a,b,c,d,e,f,g}, 1 = lit
//   SEG_0..SEG_9    BCD digit patterns
//   SEG_BLANK       all segments off
//   state_e         scan FSM states (ST_BLANK, ST_DRIVE)
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h7E;
    localparam seg_t SEG_1     = 7'h30;
    localparam seg_t SEG_2     = 7'h6D;
    localparam seg_t SEG_3     = 7'h79;
    localparam seg_t SEG_4     = 7'h33;
    localparam seg_t SEG_5     = 7'h5B;
    localparam seg_t SEG_6     = 7'h5F;
    localparam seg_t SEG_7     = 7'h70;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h7B;
    localparam seg_t SEG_BLANK = 7'h00;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_scan_ctrl_bcd_decode.sv
// seg7_bcd_decode: combinational BCD to 7-segment decode.
//   bcd  in   4-bit BCD digit
//   seg  out  segment pattern; codes 10..15 decode to blank
module seg7_bcd_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a multi-digit
// common-segment 7-segment display.
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   load        strobe, captures digits_in into the shadow frame
//   digits_in   BCD digits, digit k at [4k+3:4k], digit 0 rightmost
//   seg         registered segment bus {a..g}, 1 = lit
//   an          registered one-hot anode enable, an[k] drives digit k
//   pending     a captured frame waits for the next frame boundary
//   frame_done  one-cycle pulse in the first cycle of each new frame
// Optional feature: define SEG7_SCAN_LZB_EN for leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output seg_t                    seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic                    pending_q, pending_d;
    logic                    frame_done_q, frame_done_d;
    seg_t                    seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    wrap;
    logic [3:0]              cur_digit;
    seg_t                    dec_seg;
    logic                    lzb_blank;

    // Slot/digit sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        wrap    = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Frame buffering: shadow collects loads, active only changes on wrap
    // so a frame is never torn. A load on the wrap edge bypasses shadow.
    always_comb begin
        shadow_d     = load ? digits_in : shadow_q;
        active_d     = active_q;
        pending_d    = pending_q | load;
        frame_done_d = wrap;
        if (wrap) begin
            if (load)           active_d = digits_in;
            else if (pending_q) active_d = shadow_q;
            pending_d = 1'b0;
        end
    end

    // Outputs are registered from next-state values so that seg/an
    // line up with the FSM state of the cycle they are visible in.
    assign cur_digit = active_d[{idx_d, 2'b00} +: 4];

    seg7_bcd_decode u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

`ifdef SEG7_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  zero_above;

    // Digit k blanks when it and every higher digit are zero; digit 0 never.
    always_comb begin
        blank_mask = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_above    = zero_above && (active_d[4*k +: 4] == 4'd0);
            blank_mask[k] = zero_above;
        end
    end

    assign lzb_blank = blank_mask[idx_d];
`else
    assign lzb_blank = 1'b0;
`endif

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '0;
        if (state_d == ST_DRIVE) begin
            an_d[idx_d] = 1'b1;
            if (!lzb_blank) seg_d = dec_seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed, table-driven bench for seg7_scan_ctrl
// with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2. Cycle 0 is the first
// cycle after reset release; outputs are sampled on the falling edge.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .digits_in  (digits_in),
        .seg        (seg),
        .an         (an),
        .pending    (pending),
        .frame_done (frame_done)
    );

`ifdef SEG7_SCAN_LZB_EN
    localparam logic [6:0] ZERO_HI = 7'h00;
`else
    localparam logic [6:0] ZERO_HI = 7'h7E;
`endif

    typedef struct {
        int          cyc;
        logic        ld;
        logic [15:0] din;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        pend;
        logic        fd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, c, act, exp);
    endtask

    // Advance to cycle c; load is a one-cycle strobe.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
            load = 1'b0;
            chk("an_onehot", cyc, 32'((an & (an - 4'd1)) == 4'd0), 32'd1);
        end
    endtask

    task automatic add(input int c, input logic ld, input logic [15:0] din, input logic [3:0] a,
                       input logic [6:0] s, input logic p, input logic f);
        vec_t v;
        v.cyc = c; v.ld = ld; v.din = din; v.an = a; v.seg = s; v.pend = p; v.fd = f;
        tbl.push_back(v);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset scan of an all-zero frame
        add(0,   0, 16'h0, 4'b0000, 7'h00, 0, 0);
        add(1,   0, 16'h0, 4'b0000, 7'h00, 0, 0);
        add(2,   0, 16'h0, 4'b0001, 7'h7E, 0, 0);
        add(7,   0, 16'h0, 4'b0001, 7'h7E, 0, 0);
        add(8,   0, 16'h0, 4'b0000, 7'h00, 0, 0);
        add(10,  0, 16'h0, 4'b0010, 7'h7E, 0, 0);
        add(31,  0, 16'h0, 4'b1000, 7'h7E, 0, 0);
        add(32,  0, 16'h0, 4'b0000, 7'h00, 0, 1);
        add(33,  0, 16'h0, 4'b0000, 7'h00, 0, 0);
        add(34,  0, 16'h0, 4'b0001, 7'h7E, 0, 0);
        // mid-frame load of 1234, frame stays untorn until the boundary
        add(40,  1, 16'h1234, 4'b0000, 7'h00, 0, 0);
        add(41,  0, 16'h0, 4'b0000, 7'h00, 1, 0);
        add(42,  0, 16'h0, 4'b0010, 7'h7E, 1, 0);
        add(63,  0, 16'h0, 4'b1000, 7'h7E, 1, 0);
        add(64,  0, 16'h0, 4'b0000, 7'h00, 0, 1);
        add(65,  0, 16'h0, 4'b0000, 7'h00, 0, 0);
        add(66,  0, 16'h0, 4'b0001, 7'h33, 0, 0);
        // 1111 then 5678 before the boundary: last load wins
        add(70,  1, 16'h1111, 4'b0001, 7'h33, 0, 0);
        add(74,  0, 16'h0, 4'b0010, 7'h79, 1, 0);
        add(80,  1, 16'h5678, 4'b0000, 7'h00, 1, 0);
        add(82,  0, 16'h0, 4'b0100, 7'h6D, 1, 0);
        add(90,  0, 16'h0, 4'b1000, 7'h30, 1, 0);
        add(96,  0, 16'h0, 4'b0000, 7'h00, 0, 1);
        add(98,  0, 16'h0, 4'b0001, 7'h7F, 0, 0);
        add(106, 0, 16'h0, 4'b0010, 7'h70, 0, 0);
        add(114, 0, 16'h0, 4'b0100, 7'h5F, 0, 0);
        add(115, 1, 16'h4321, 4'b0100, 7'h5F, 0, 0);
        add(122, 0, 16'h0, 4'b1000, 7'h5B, 1, 0);
        // load on the wrap edge goes straight to active
        add(127, 1, 16'h00A9, 4'b1000, 7'h5B, 1, 0);
        add(128, 0, 16'h0, 4'b0000, 7'h00, 0, 1);
        add(130, 0, 16'h0, 4'b0001, 7'h7B, 0, 0);
        add(138, 0, 16'h0, 4'b0010, 7'h00, 0, 0);
        add(146, 0, 16'h0, 4'b0100, ZERO_HI, 0, 0);
        add(154, 0, 16'h0, 4'b1000, ZERO_HI, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst_an", -1, 32'(an), 32'h0);
        chk("rst_seg", -1, 32'(seg), 32'h0);
        release_rst();

        foreach (tbl[i]) begin
            goto(tbl[i].cyc);
            chk("an",         cyc, 32'(an),         32'(tbl[i].an));
            chk("seg",        cyc, 32'(seg),        32'(tbl[i].seg));
            chk("pending",    cyc, 32'(pending),    32'(tbl[i].pend));
            chk("frame_done", cyc, 32'(frame_done), 32'(tbl[i].fd));
            if (tbl[i].ld) begin
                load      = 1'b1;
                digits_in = tbl[i].din;
            end
        end

        // reset during DRIVE of digit 2 with a load pending
        goto(170);
        load = 1'b1;
        digits_in = 16'h9999;
        goto(171);
        chk("pend_pre_rst", cyc, 32'(pending), 32'd1);
        goto(179);
        chk("an_pre_rst", cyc, 32'(an), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("an_in_rst",      cyc, 32'(an),         32'h0);
        chk("seg_in_rst",     cyc, 32'(seg),        32'h0);
        chk("pending_in_rst", cyc, 32'(pending),    32'h0);
        chk("fd_in_rst",      cyc, 32'(frame_done), 32'h0);
        release_rst();
        goto(2);
        chk("an_post_rst",  cyc, 32'(an),  32'h1);
        chk("seg_post_rst", cyc, 32'(seg), 32'h7E);
        goto(32);
        chk("fd_post_rst", cyc, 32'(frame_done), 32'd1);
        goto(34);
        chk("seg_discard", cyc, 32'(seg),     32'h7E);
        chk("pend_discard", cyc, 32'(pending), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
